// File: rtl/riscv_core_div_iter_out_if.sv
// Handshake and operand bundle between the divider input stage / EX-MEM and the
// iterative divider output stage.
interface riscv_core_div_iter_out_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            i_valid;
  logic            o_ready;
  logic [XLEN-1:0] i_dividend;
  logic [XLEN-1:0] i_divisor;
  logic            i_srcA_sign;
  logic            i_srcB_sign;
  logic [1:0]      i_control;
  logic            i_isword;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;

  modport slave (
    input  i_valid, i_dividend, i_divisor, i_srcA_sign, i_srcB_sign,
           i_control, i_isword, i_flush, i_ready,
    output o_ready, o_valid, o_result
  );

  modport master (
    output i_valid, i_dividend, i_divisor, i_srcA_sign, i_srcB_sign,
           i_control, i_isword, i_flush, i_ready,
    input  o_ready, o_valid, o_result
  );
endinterface

// File: rtl/riscv_core_div_iter_out.sv
// Iterative radix-2 restoring divider with RISC-V M sign restore (DIV/DIVU/REM/REMU, W forms).
// Optional RISCV_DIV_EARLY_OUT_EN: skip iteration when divisor > dividend (latency only).
module riscv_core_div_iter_out #(
  parameter int unsigned XLEN = 32
) (
  input logic                      i_clk,
  input logic                      i_rst_n,
  riscv_core_div_iter_out_if.slave bus
);
  localparam int unsigned HALF = XLEN / 2;
  localparam int unsigned CW   = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] quo_q, rem_q, dsr_q, result_q;
  logic [CW-1:0]   count_q;
  logic            a_sign_q, b_sign_q, isword_q, div0_q;
  logic [1:0]      ctrl_q;

  logic            accept, div0_in, early_in;
  logic [XLEN:0]   shifted;
  logic            ge;
  logic [XLEN-1:0] rem_step, quo_step;
  logic [XLEN-1:0] sel, signed_res, fix_result;
  logic            neg;

  assign bus.o_ready  = (state_q == IDLE);
  assign bus.o_valid  = (state_q == DONE);
  assign bus.o_result = result_q;

  always_comb begin
    div0_in = (bus.i_divisor == '0);
`ifdef RISCV_DIV_EARLY_OUT_EN
    early_in = !div0_in && (bus.i_divisor > bus.i_dividend);
`else
    early_in = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (bus.i_valid) begin
        accept  = 1'b1;
        state_d = (div0_in || early_in) ? FIX : CALC;
      end
      CALC: if (count_q == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (bus.i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.i_flush) begin
      state_d = IDLE;
      accept  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // One restoring step; the shifted remainder needs XLEN+1 bits for the compare,
  // but a successful subtraction always fits back into XLEN bits.
  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    ge       = (shifted >= {1'b0, dsr_q});
    rem_step = ge ? (shifted[XLEN-1:0] - dsr_q) : shifted[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], ge};
  end

  always_comb begin
    sel        = ctrl_q[1] ? rem_q : quo_q;
    neg        = !ctrl_q[0] && (ctrl_q[1] ? a_sign_q : ((a_sign_q ^ b_sign_q) && !div0_q));
    signed_res = neg ? (-sel) : sel;
    fix_result = isword_q ? {{HALF{signed_res[HALF-1]}}, signed_res[HALF-1:0]} : signed_res;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      result_q <= '0;
      count_q  <= '0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      isword_q <= 1'b0;
      div0_q   <= 1'b0;
      ctrl_q   <= '0;
    end else if (accept) begin
      dsr_q    <= bus.i_divisor;
      a_sign_q <= bus.i_srcA_sign;
      b_sign_q <= bus.i_srcB_sign;
      ctrl_q   <= bus.i_control;
      isword_q <= bus.i_isword;
      div0_q   <= div0_in;
      count_q  <= bus.i_isword ? CW'(HALF - 1) : CW'(XLEN - 1);
      if (div0_in) begin
        quo_q <= '1;
        rem_q <= bus.i_dividend;
      end else if (early_in) begin
        quo_q <= '0;
        rem_q <= bus.i_dividend;
      end else begin
        // Word dividends are parked in the upper half so their MSB shifts out first.
        quo_q <= bus.i_isword ? {bus.i_dividend[HALF-1:0], {HALF{1'b0}}} : bus.i_dividend;
        rem_q <= '0;
      end
    end else if (state_q == CALC && !bus.i_flush) begin
      quo_q   <= quo_step;
      rem_q   <= rem_step;
      count_q <= count_q - 1'b1;
    end else if (state_q == FIX && !bus.i_flush) begin
      result_q <= fix_result;
    end
  end
endmodule

// File: tb/tb_riscv_core_div_iter_out.sv
// Directed-vector bench for riscv_core_div_iter_out with hand-computed results and latencies.
module tb_riscv_core_div_iter_out;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  riscv_core_div_iter_out_if #(.XLEN(32)) bus ();

  riscv_core_div_iter_out #(.XLEN(32)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

`ifdef RISCV_DIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 33;
`endif

  typedef struct {
    string       tag;
    logic [1:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic        sa;
    logic        sb;
    logic        w;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic sa, input logic sb, input logic w,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    bus.i_control   = c;
    bus.i_dividend  = a;
    bus.i_divisor   = b;
    bus.i_srcA_sign = sa;
    bus.i_srcB_sign = sb;
    bus.i_isword    = w;
    bus.i_ready     = 1'b1;
    bus.i_valid     = 1'b1;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    lat = 0;
    while (!bus.o_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, ".valid"}, 32'(bus.o_valid), 32'd1);
    res = bus.o_result;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] res;
    int          lat;
    logic        seen;

    bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_flush = 1'b0;
    bus.i_dividend = '0; bus.i_divisor = '0; bus.i_srcA_sign = 1'b0;
    bus.i_srcB_sign = 1'b0; bus.i_control = '0; bus.i_isword = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst.ready",  32'(bus.o_ready), 32'd1);
    check("rst.valid",  32'(bus.o_valid), 32'd0);
    check("rst.result", bus.o_result, 32'h0);
    rst_n = 1'b1;

    vecs.push_back('{"div_7_2",     2'b00, 32'd7,          32'd2,          1, 0, 0, 32'hFFFF_FFFD, 33});
    vecs.push_back('{"rem_7_2",     2'b10, 32'd7,          32'd2,          1, 0, 0, 32'hFFFF_FFFF, 33});
    vecs.push_back('{"remu_7_2",    2'b11, 32'd7,          32'd2,          0, 0, 0, 32'h0000_0001, 33});
    vecs.push_back('{"divu_by0",    2'b01, 32'h1234,       32'd0,          0, 0, 0, 32'hFFFF_FFFF, 1});
    vecs.push_back('{"rem_by0",     2'b10, 32'h1234,       32'd0,          1, 0, 0, 32'hFFFF_EDCC, 1});
    vecs.push_back('{"div_ovf",     2'b00, 32'h8000_0000,  32'd1,          1, 1, 0, 32'h8000_0000, 33});
    vecs.push_back('{"rem_ovf",     2'b10, 32'h8000_0000,  32'd1,          1, 1, 0, 32'h0000_0000, 33});
    vecs.push_back('{"divw_ovf",    2'b00, 32'h8000,       32'd1,          1, 1, 1, 32'hFFFF_8000, 17});
    vecs.push_back('{"div_100_n7",  2'b00, 32'd100,        32'd7,          0, 1, 0, 32'hFFFF_FFF2, 33});
    vecs.push_back('{"rem_100_n7",  2'b10, 32'd100,        32'd7,          0, 1, 0, 32'h0000_0002, 33});
    vecs.push_back('{"remw_n7_2",   2'b10, 32'd7,          32'd2,          1, 0, 1, 32'hFFFF_FFFF, 17});
    vecs.push_back('{"divuw_ffff",  2'b01, 32'h0000_FFFF,  32'd1,          0, 0, 1, 32'hFFFF_FFFF, 17});
    vecs.push_back('{"divu_max",    2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 0, 0, 32'h0000_0001, 33});
    vecs.push_back('{"divu_max_2",  2'b01, 32'hFFFF_FFFF,  32'd2,          0, 0, 0, 32'h7FFF_FFFF, 33});
    vecs.push_back('{"remu_max_16", 2'b11, 32'hFFFF_FFFF,  32'h10,         0, 0, 0, 32'h0000_000F, 33});
    vecs.push_back('{"divu_3_10",   2'b01, 32'd3,          32'd10,         0, 0, 0, 32'h0000_0000, EO_LAT});
    vecs.push_back('{"remu_3_10",   2'b11, 32'd3,          32'd10,         0, 0, 0, 32'h0000_0003, EO_LAT});

    foreach (vecs[i]) begin
      run_op(vecs[i].tag, vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, vecs[i].w,
             res, lat);
      check({vecs[i].tag, ".result"}, res, vecs[i].exp);
      check({vecs[i].tag, ".latency"}, 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: REMU 100/7 = 2 held in DONE while extra requests arrive.
    @(negedge clk);
    bus.i_control = 2'b11; bus.i_dividend = 32'd100; bus.i_divisor = 32'd7;
    bus.i_srcA_sign = 1'b0; bus.i_srcB_sign = 1'b0; bus.i_isword = 1'b0;
    bus.i_ready = 1'b0; bus.i_valid = 1'b1;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    lat = 0;
    while (!bus.o_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check("bp.first_valid", 32'(bus.o_valid), 32'd1);
    bus.i_dividend = 32'd9; bus.i_divisor = 32'd3;
    for (int k = 0; k < 5; k++) begin
      bus.i_valid = (k % 2 == 0);
      @(posedge clk);
      #1;
      check("bp.valid",  32'(bus.o_valid), 32'd1);
      check("bp.result", bus.o_result, 32'h0000_0002);
      check("bp.ready",  32'(bus.o_ready), 32'd0);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp.release_ready", 32'(bus.o_ready), 32'd1);
    check("bp.release_valid", 32'(bus.o_valid), 32'd0);

    // Flush during CALC.
    @(negedge clk);
    bus.i_control = 2'b01; bus.i_dividend = 32'd100; bus.i_divisor = 32'd7;
    bus.i_valid = 1'b1;
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.i_flush = 1'b1;
    @(posedge clk);
    #1 bus.i_flush = 1'b0;
    check("flush.ready", 32'(bus.o_ready), 32'd1);
    check("flush.valid", 32'(bus.o_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 seen |= bus.o_valid;
    end
    check("flush.no_result", 32'(seen), 32'd0);
    run_op("post_flush", 2'b01, 32'd9, 32'd3, 1'b0, 1'b0, 1'b0, res, lat);
    check("post_flush.result", res, 32'h0000_0003);
    check("post_flush.latency", 32'(lat), 32'd33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
